// File: rtl/rot_cordic_arbiter_pkg.sv
// Shared constants and width helpers for the rotational CORDIC arbiter.
// Contents:
//   DEF_*      default parameter values for the arbiter
//   idx_width  index width that never collapses to zero bits
//   cnt_width  width of an occupancy counter that must reach 'depth'
package rot_cordic_arbiter_pkg;

    localparam int unsigned DEF_WORDLEN      = 16;
    localparam int unsigned DEF_N_REQ        = 3;
    localparam int unsigned DEF_MAX_INFLIGHT = 16;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rot_tag_fifo.sv
// Synchronous FIFO holding the requester tag of each op in flight through the CORDIC.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   push, wdata   enqueue wdata (ignored when full)
//   pop, rdata    dequeue head (ignored when empty); rdata shows the head combinationally
//   full, empty   occupancy flags
//   count         number of stored entries
module rot_tag_fifo
    import rot_cordic_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [cnt_width(DEPTH)-1:0]  count
);

    localparam int unsigned PW = idx_width(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rot_cordic_arbiter.sv
// Shares one in-order pipelined rotational CORDIC among N_REQ column-update engines.
// Round-robin grant, one-cycle issue register, tag FIFO of ops in flight, and a
// response register that routes each CORDIC result back to its requester.
// Ports:
//   CLK, RST                        clock, asynchronous active-high reset
//   req_valid/req_ready             per-requester handshake (req_ready one-hot or zero)
//   req_opr1/req_opr2/req_theta     packed operands, requester i at [i*WORDLEN +: WORDLEN]
//   rot_valid/rot_opr1/2/rot_theta  registered issue to the CORDIC
//   rot_done/rot_out1/2             CORDIC result strobe and data
//   rsp_valid/rsp_out1/2            one-hot result strobe and shared result bus
//   busy                            ops in flight or an issue pending
//   err_unflw                       sticky: result arrived with no op in flight
module rot_cordic_arbiter
    import rot_cordic_arbiter_pkg::*;
#(
    parameter int unsigned WORDLEN      = DEF_WORDLEN,
    parameter int unsigned N_REQ        = DEF_N_REQ,
    parameter int unsigned MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*WORDLEN-1:0]   req_opr1,
    input  logic [N_REQ*WORDLEN-1:0]   req_opr2,
    input  logic [N_REQ*WORDLEN-1:0]   req_theta,
    output logic                       rot_valid,
    output logic [WORDLEN-1:0]         rot_opr1,
    output logic [WORDLEN-1:0]         rot_opr2,
    output logic [WORDLEN-1:0]         rot_theta,
    input  logic                       rot_done,
    input  logic [WORDLEN-1:0]         rot_out1,
    input  logic [WORDLEN-1:0]         rot_out2,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [WORDLEN-1:0]         rsp_out1,
    output logic [WORDLEN-1:0]         rsp_out2,
    output logic                       busy,
    output logic                       err_unflw
);

    localparam int unsigned TAG_W = idx_width(N_REQ);
    localparam int unsigned CW    = cnt_width(MAX_INFLIGHT);
    localparam logic [TAG_W-1:0] LAST_REQ = TAG_W'(N_REQ - 1);

    logic [TAG_W-1:0] ptr;
    logic [TAG_W-1:0] grant_idx;
    logic [TAG_W-1:0] head_tag;
    logic [N_REQ-1:0] grant;
    logic             accept;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

    // Round-robin search starting at ptr. Gated on the pre-pop FIFO state, so a full
    // FIFO stalls the grant for the cycle its head is popped.
    always_comb begin
        int               cand;
        logic [TAG_W-1:0] cidx;
        grant     = '0;
        grant_idx = '0;
        accept    = 1'b0;
        cand      = 0;
        cidx      = '0;
        if (!fifo_full && !RST) begin
            for (int k = 0; k < int'(N_REQ); k++) begin
                cand = int'(ptr) + k;
                if (cand >= int'(N_REQ)) begin
                    cand = cand - int'(N_REQ);
                end
                cidx = TAG_W'(cand);
                if (!accept && req_valid[cidx]) begin
                    accept      = 1'b1;
                    grant[cidx] = 1'b1;
                    grant_idx   = cidx;
                end
            end
        end
    end

    assign req_ready = grant;
    assign pop       = rot_done & ~fifo_empty;
    assign busy      = ~fifo_empty | rot_valid;

    rot_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (accept),
        .wdata (grant_idx),
        .pop   (pop),
        .rdata (head_tag),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Issue register: operands hold when nothing is accepted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr       <= '0;
            rot_valid <= 1'b0;
            rot_opr1  <= '0;
            rot_opr2  <= '0;
            rot_theta <= '0;
        end else begin
            rot_valid <= accept;
            if (accept) begin
                ptr       <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
                rot_opr1  <= req_opr1[grant_idx*WORDLEN +: WORDLEN];
                rot_opr2  <= req_opr2[grant_idx*WORDLEN +: WORDLEN];
                rot_theta <= req_theta[grant_idx*WORDLEN +: WORDLEN];
            end
        end
    end

    // Response register: CORDIC is in-order, so the FIFO head names the owner.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_valid <= '0;
            rsp_out1  <= '0;
            rsp_out2  <= '0;
            err_unflw <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (pop) begin
                rsp_valid[head_tag] <= 1'b1;
                rsp_out1            <= rot_out1;
                rsp_out2            <= rot_out2;
            end
            if (rot_done && fifo_empty) begin
                err_unflw <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rot_cordic_arbiter.sv
// Self-checking bench for rot_cordic_arbiter (N_REQ=3, MAX_INFLIGHT=4).
// A behavioural CORDIC stand-in returns out1=opr1+theta, out2=opr2^theta.
module tb_rot_cordic_arbiter;

    localparam int WL = 16;
    localparam int NR = 3;
    localparam int MI = 4;

    typedef struct packed {
        logic [1:0]    tag;
        logic [WL-1:0] a;
        logic [WL-1:0] b;
        logic [WL-1:0] c;
    } op_t;

    typedef struct packed {
        logic [NR-1:0] v;
        logic [NR-1:0] rdy;
    } vec_t;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*WL-1:0]  req_opr1;
    logic [NR*WL-1:0]  req_opr2;
    logic [NR*WL-1:0]  req_theta;
    logic              rot_valid;
    logic [WL-1:0]     rot_opr1;
    logic [WL-1:0]     rot_opr2;
    logic [WL-1:0]     rot_theta;
    logic              rot_done;
    logic [WL-1:0]     rot_out1;
    logic [WL-1:0]     rot_out2;
    logic [NR-1:0]     rsp_valid;
    logic [WL-1:0]     rsp_out1;
    logic [WL-1:0]     rsp_out2;
    logic              busy;
    logic              err_unflw;

    int checks = 0;
    int errors = 0;

    op_t        issue_q[$];
    op_t        cq[$];
    op_t        rsp_q[$];
    logic [1:0] tag_q[$];
    logic       exp_err = 1'b0;

    logic [WL-1:0] op1 [NR];
    logic [WL-1:0] op2 [NR];
    logic [WL-1:0] th  [NR];

    vec_t tbl [18];

    rot_cordic_arbiter #(
        .WORDLEN      (WL),
        .N_REQ        (NR),
        .MAX_INFLIGHT (MI)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opr1  (req_opr1),
        .req_opr2  (req_opr2),
        .req_theta (req_theta),
        .rot_valid (rot_valid),
        .rot_opr1  (rot_opr1),
        .rot_opr2  (rot_opr2),
        .rot_theta (rot_theta),
        .rot_done  (rot_done),
        .rot_out1  (rot_out1),
        .rot_out2  (rot_out2),
        .rsp_valid (rsp_valid),
        .rsp_out1  (rsp_out1),
        .rsp_out2  (rsp_out2),
        .busy      (busy),
        .err_unflw (err_unflw)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One clock: drive at posedge+1, check and update the model at negedge.
    task automatic tick(input logic [NR-1:0] v, input logic [NR-1:0] exp_rdy,
                        input bit done_en, input bit done_force, input string nm);
        op_t           o;
        op_t           e;
        logic [NR-1:0] acc;
        logic [NR-1:0] exp_rsp;
        logic [1:0]    t;
        logic          exp_busy;
        bit            taken;
        req_valid = v;
        for (int i = 0; i < NR; i++) begin
            req_opr1[i*WL +: WL]  = op1[i];
            req_opr2[i*WL +: WL]  = op2[i];
            req_theta[i*WL +: WL] = th[i];
        end
        rot_done = 1'b0;
        rot_out1 = '0;
        rot_out2 = '0;
        if (done_en && cq.size() > 0) begin
            o        = cq.pop_front();
            rot_done = 1'b1;
            rot_out1 = o.a;
            rot_out2 = o.b;
        end else if (done_force) begin
            rot_done = 1'b1;
            rot_out1 = 16'hDEAD;
            rot_out2 = 16'hBEEF;
        end
        @(negedge CLK);
        chk({nm, " req_ready"}, 32'(req_ready), 32'(exp_rdy));
        exp_busy = (tag_q.size() != 0);
        if (issue_q.size() > 0) begin
            e        = issue_q.pop_front();
            exp_busy = 1'b1;
            chk({nm, " rot_valid"}, 32'(rot_valid), 32'd1);
            chk({nm, " rot_opr1"}, 32'(rot_opr1), 32'(e.a));
            chk({nm, " rot_opr2"}, 32'(rot_opr2), 32'(e.b));
            chk({nm, " rot_theta"}, 32'(rot_theta), 32'(e.c));
            o.tag = e.tag;
            o.a   = e.a + e.c;
            o.b   = e.b ^ e.c;
            o.c   = '0;
            cq.push_back(o);
        end else begin
            chk({nm, " rot_valid idle"}, 32'(rot_valid), 32'd0);
        end
        if (rsp_q.size() > 0) begin
            e          = rsp_q.pop_front();
            exp_rsp    = '0;
            exp_rsp[e.tag] = 1'b1;
            chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'(exp_rsp));
            chk({nm, " rsp_out1"}, 32'(rsp_out1), 32'(e.a));
            chk({nm, " rsp_out2"}, 32'(rsp_out2), 32'(e.b));
        end else begin
            chk({nm, " rsp_valid idle"}, 32'(rsp_valid), 32'd0);
        end
        chk({nm, " busy"}, 32'(busy), 32'(exp_busy));
        chk({nm, " err_unflw"}, 32'(err_unflw), 32'(exp_err));
        // Pop uses the pre-accept FIFO state.
        if (rot_done) begin
            if (tag_q.size() > 0) begin
                t     = tag_q.pop_front();
                e.tag = t;
                e.a   = rot_out1;
                e.b   = rot_out2;
                e.c   = '0;
                rsp_q.push_back(e);
            end else begin
                exp_err = 1'b1;
            end
        end
        acc   = req_valid & req_ready;
        taken = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (acc[i] && !taken) begin
                taken = 1'b1;
                e.tag = 2'(i);
                e.a   = op1[i];
                e.b   = op2[i];
                e.c   = th[i];
                issue_q.push_back(e);
                tag_q.push_back(2'(i));
                op1[i] = op1[i] + 16'h0123;
                op2[i] = op2[i] - 16'h0457;
                th[i]  = th[i] + 16'h0031;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic [NR-1:0] v);
        req_valid = v;
        rot_done  = 1'b0;
        RST       = 1'b1;
        #1;
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst rot_valid", 32'(rot_valid), 32'd0);
        chk("rst rot_opr1", 32'(rot_opr1), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_out1", 32'(rsp_out1), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst err_unflw", 32'(err_unflw), 32'd0);
        issue_q.delete();
        cq.delete();
        rsp_q.delete();
        tag_q.delete();
        exp_err = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((issue_q.size() + cq.size() + rsp_q.size() + tag_q.size()) != 0 && n < 30) begin
            tick(3'b000, 3'b000, 1'b1, 1'b0, nm);
            n++;
        end
        chk({nm, " drain bound"}, 32'(issue_q.size() + cq.size() + rsp_q.size() + tag_q.size()),
            32'd0);
        tick(3'b000, 3'b000, 1'b1, 1'b0, {nm, " idle"});
    endtask

    initial begin
        // Round-robin table starting from ptr=0: rotation, fairness with an idle requester,
        // late-raised requester, idle cycle, and wrap-around searches.
        tbl[0]  = '{v: 3'b111, rdy: 3'b001};
        tbl[1]  = '{v: 3'b111, rdy: 3'b010};
        tbl[2]  = '{v: 3'b111, rdy: 3'b100};
        tbl[3]  = '{v: 3'b111, rdy: 3'b001};
        tbl[4]  = '{v: 3'b111, rdy: 3'b010};
        tbl[5]  = '{v: 3'b111, rdy: 3'b100};
        tbl[6]  = '{v: 3'b101, rdy: 3'b001};
        tbl[7]  = '{v: 3'b101, rdy: 3'b100};
        tbl[8]  = '{v: 3'b101, rdy: 3'b001};
        tbl[9]  = '{v: 3'b101, rdy: 3'b100};
        tbl[10] = '{v: 3'b111, rdy: 3'b001};
        tbl[11] = '{v: 3'b111, rdy: 3'b010};
        tbl[12] = '{v: 3'b000, rdy: 3'b000};
        tbl[13] = '{v: 3'b100, rdy: 3'b100};
        tbl[14] = '{v: 3'b010, rdy: 3'b010};
        tbl[15] = '{v: 3'b001, rdy: 3'b001};
        tbl[16] = '{v: 3'b011, rdy: 3'b010};
        tbl[17] = '{v: 3'b110, rdy: 3'b100};

        for (int i = 0; i < NR; i++) begin
            op1[i] = 16'(16'h2000 * (i + 1));
            op2[i] = 16'(16'h0300 + i);
            th[i]  = 16'(16'h0040 * (i + 1));
        end
        req_valid = '0;
        req_opr1  = '0;
        req_opr2  = '0;
        req_theta = '0;
        rot_done  = 1'b0;
        rot_out1  = '0;
        rot_out2  = '0;
        do_reset(3'b111);

        // Single op from requester 1.
        op1[1] = 16'h1000;
        op2[1] = 16'h0000;
        th[1]  = 16'h0C90;
        tick(3'b010, 3'b010, 1'b0, 1'b0, "single grant");
        tick(3'b000, 3'b000, 1'b0, 1'b0, "single issue");
        tick(3'b000, 3'b000, 1'b1, 1'b0, "single done");
        tick(3'b000, 3'b000, 1'b0, 1'b0, "single rsp");
        chk("single rsp_out1 value", 32'(rsp_out1), 32'h1C90);
        chk("single rsp_out2 value", 32'(rsp_out2), 32'h0C90);

        do_reset(3'b000);
        for (int i = 0; i < 18; i++) begin
            tick(tbl[i].v, tbl[i].rdy, 1'b1, 1'b0, $sformatf("tbl%0d", i));
        end
        drain("tbl");

        // Fill to MAX_INFLIGHT with the CORDIC stalled.
        tick(3'b111, 3'b001, 1'b0, 1'b0, "fill0");
        tick(3'b111, 3'b010, 1'b0, 1'b0, "fill1");
        tick(3'b111, 3'b100, 1'b0, 1'b0, "fill2");
        tick(3'b111, 3'b001, 1'b0, 1'b0, "fill3");
        tick(3'b111, 3'b000, 1'b0, 1'b0, "full a");
        tick(3'b111, 3'b000, 1'b0, 1'b0, "full b");
        tick(3'b111, 3'b000, 1'b1, 1'b0, "pop while full");
        tick(3'b111, 3'b010, 1'b0, 1'b0, "regrant");
        tick(3'b111, 3'b000, 1'b0, 1'b0, "full again");
        drain("full");

        // Result strobe with nothing in flight.
        tick(3'b000, 3'b000, 1'b0, 1'b1, "underflow");
        tick(3'b000, 3'b000, 1'b0, 1'b0, "err sticky a");
        tick(3'b000, 3'b000, 1'b0, 1'b0, "err sticky b");

        // Reset with ops in flight and ptr left at 2.
        tick(3'b111, 3'b100, 1'b1, 1'b0, "mid0");
        tick(3'b111, 3'b001, 1'b1, 1'b0, "mid1");
        tick(3'b111, 3'b010, 1'b1, 1'b0, "mid2");
        do_reset(3'b110);
        tick(3'b110, 3'b010, 1'b1, 1'b0, "post reset");
        drain("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
